// File: rtl/regfile_2r1w_pkg.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_pkg
//
// Shared CPU register-file definitions:
//   NREGS         number of architectural registers
//   REG_AW        register-address width
//   ZERO_REG      address of the hardwired-zero register
//   DEFAULT_WIDTH default data width of each register
//
// Also holds the enabled 5-to-32 write-address decoder. It produces the
// one-hot write-enable vector consumed by the register array.
// -----------------------------------------------------------------------------
package regfile_2r1w_pkg;

  localparam int NREGS         = 32;
  localparam int REG_AW        = 5;
  localparam int DEFAULT_WIDTH = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [NREGS-1:0]  wen_vec_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // Enabled one-hot decode of the write address.
  // The result is all-zero when we=0. Bit 0 is always clear, so the zero
  // register can never be written.
  // The address is only used as an index once we=1 has been seen. An unknown
  // wn therefore cannot leak into the vector while writes are disabled.
  function automatic wen_vec_t decode_wen(input logic we, input reg_addr_t wn);
    wen_vec_t v;
    v = '0;
    if (we) begin
      if (wn != ZERO_REG) begin
        v[wn] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/regfile_2r1w_reg32e.sv
// -----------------------------------------------------------------------------
// reg32e
//
// WIDTH-bit register with a load enable and an asynchronous active-low clear.
// One instance holds one general-purpose register of the register file.
//
// Ports:
//   Clk   input  1      rising-edge clock
//   Clrn  input  1      asynchronous active-low clear (Q -> 0 immediately)
//   E     input  1      load enable; Q takes D on the rising edge when set
//   D     input  WIDTH  data to load
//   Q     output WIDTH  stored value
// -----------------------------------------------------------------------------
module reg32e
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // NOTE: clocked state is updated with non-blocking assignments. Every flop
  // then samples pre-edge values, whatever order the simulator evaluates
  // the processes in.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Q <= '0;
    end else if (E) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// 32-entry general-purpose register file with two combinational read ports
// (rs/rt operand fetch) and one clocked write port (writeback).
// Register 0 is hardwired to zero.
//
// Parameters:
//   WIDTH   data width of each register
//   BYPASS  1: a write pending on this cycle's edge is forwarded to a read
//              port that addresses the same register (write-through).
//           0: reads always return the pre-edge contents.
//
// Ports:
//   Clk   input  1       system clock; writes occur on the rising edge
//   Clrn  input  1       asynchronous active-low reset; clears every register
//   Rna   input  5       read address, port A
//   Rnb   input  5       read address, port B
//   Wn    input  5       write address
//   We    input  1       write enable
//   D     input  WIDTH   write data
//   Qa    output WIDTH   read data, port A
//   Qb    output WIDTH   read data, port B
//
// Reset deassertion is synchronised by the enclosing top level.
// -----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit BYPASS = 1'b0
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [REG_AW-1:0] Rna,
  input  logic [REG_AW-1:0] Rnb,
  input  logic [REG_AW-1:0] Wn,
  input  logic              We,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Qa,
  output logic [WIDTH-1:0]  Qb
);

  wen_vec_t         wen;
  logic             wen0_unused;
  logic [WIDTH-1:0] regs [NREGS];
  logic             byp_a;
  logic             byp_b;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  assign wen = decode_wen(We, Wn);

  // Bit 0 is always zero and has no register to drive.
  assign wen0_unused = wen[0];

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // The zero register is a constant, not a flop. It ignores writes and needs
  // no clear.
  assign regs[0] = '0;

  // NOTE: every storage flop gets the asynchronous clear. Reset has to leave
  // all architectural registers at zero, so this array cannot be built as a
  // reset-less RAM.
  for (genvar k = 1; k < NREGS; k++) begin : g_reg
    reg32e #(
      .WIDTH (WIDTH)
    ) u_reg (
      .Clk  (Clk),
      .Clrn (Clrn),
      .E    (wen[k]),
      .D    (D),
      .Q    (regs[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Read ports with optional write-through
  // ---------------------------------------------------------------------------
  // A bypass hit needs a real write this cycle: We=1, reset released, and a
  // non-zero destination. Wn is compared only after We has qualified it.
  // This keeps an unknown Wn from reaching the outputs while writes are off.
  // The Clrn term keeps both ports at zero while reset is held.
  // NOTE: every signal assigned here gets a default before any condition.
  // Otherwise a path that leaves it unassigned would infer a latch.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (BYPASS && Clrn && We && (Wn != ZERO_REG)) begin
      byp_a = (Wn == Rna);
      byp_b = (Wn == Rnb);
    end
    Qa = byp_a ? D : regs[Rna];
    Qb = byp_b ? D : regs[Rnb];
  end

endmodule
